ntt_seq_ctrl: RTL and testbench

Sequencer for one NTT transform over a shared single-port BRAM. On `start` it reads N input coefficients from BRAM into the NTT input buffer, releases the NTT core from reset, and waits for its `done`. It then writes the N outputs back to a destination region and pulses `done_o`. It sits between the host-visible start/status logic and the `ntt` core, and it is the only driver of the BRAM port.

---
 rtl/ntt_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_ntt_seq_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ntt_seq_ctrl
// Brief    : Sequences one NTT transform over a shared single-port BRAM:
//            loads N coefficients into the NTT input buffer, runs the core,
//            waits for its done (with timeout), then writes N results back.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_seq_ctrl #(
  parameter int N          = 64,
  parameter int DW         = 64,
  parameter int AW         = 13,
  parameter int ADDR_SHIFT = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [AW-ADDR_SHIFT-1:0] src_base,
  input  logic [AW-ADDR_SHIFT-1:0] dst_base,
  output logic                     busy,
  output logic                     done_o,
  output logic                     err,
  output logic                     BRAM_clk,
  output logic                     BRAM_en,
  output logic                     BRAM_we,
  output logic [AW-1:0]            BRAM_addr,
  output logic [DW-1:0]            BRAM_din,
  input  logic [DW-1:0]            BRAM_dout,
  output logic                     ntt_rst,
  input  logic                     ntt_done,
  output logic                     ld_valid,
  output logic [$clog2(N)-1:0]     ld_idx,
  output logic [DW-1:0]            ld_data,
  output logic [$clog2(N)-1:0]     st_idx,
  input  logic [DW-1:0]            st_data
);

  localparam int LW = $clog2(N);
  localparam int CW = LW + 1;
  localparam int WW = AW - ADDR_SHIFT;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] C_CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_CNT_N    = CW'(N);
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_LTAIL = 3'd2,
    S_RUN   = 3'd3,
    S_STORE = 3'd4,
    S_FIN   = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WW-1:0]   r_src;
  logic [WW-1:0]   r_dst;
  logic [CW-1:0]   r_cnt;      // read index r in LOAD, write index w in RUN/STORE
  logic [TW-1:0]   r_tmo;
  logic            r_en;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_din;
  logic            r_err;
  logic            r_ld_valid;
  logic [LW-1:0]   r_ld_idx;

  logic [WW-1:0]   w_rd_idx;
  logic [WW-1:0]   w_wr_idx;
  logic            w_tmo_hit;
  logic            w_wr_issue;

  // Next read word is one past the address currently on the port; word
  // indices wrap naturally at the WW-bit width.
  assign w_rd_idx   = r_src + WW'(r_cnt) + WW'(1);
  assign w_wr_idx   = r_dst + WW'(r_cnt);
  assign w_tmo_hit  = (r_tmo == C_TMO_LAST);
  // Write of word w is registered in the cycle st_idx=w; the first one is
  // issued from the RUN cycle that sees ntt_done so writes start at D+1.
  assign w_wr_issue = !abort &&
                      (((r_state == S_RUN) && ntt_done) ||
                       ((r_state == S_STORE) && (r_cnt != C_CNT_N)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and state-derived status outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done_o      = 1'b0;
    ntt_rst     = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (r_cnt == C_CNT_LAST) w_state_nxt = S_LTAIL;
      end
      S_LTAIL: begin
        busy        = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        ntt_rst = 1'b0;
        if (ntt_done)       w_state_nxt = S_STORE;
        else if (w_tmo_hit) w_state_nxt = S_ERR;
      end
      S_STORE: begin
        busy    = 1'b1;
        ntt_rst = 1'b0;
        if (r_cnt == C_CNT_N) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
  end

  // Datapath: counters, BRAM port registers, load strobe and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_err      <= 1'b0;
      r_ld_valid <= 1'b0;
      r_ld_idx   <= '0;
    end else begin
      r_en       <= 1'b0;
      r_we       <= 1'b0;
      r_ld_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src  <= src_base;
            r_dst  <= dst_base;
            r_err  <= 1'b0;
            r_cnt  <= '0;
            r_en   <= 1'b1;
            r_addr <= AW'(src_base) << ADDR_SHIFT;
          end
        end
        S_LOAD: begin
          if (!abort) begin
            // Data for the address on the port now returns next cycle.
            r_ld_valid <= 1'b1;
            r_ld_idx   <= r_cnt[LW-1:0];
            if (r_cnt != C_CNT_LAST) begin
              r_cnt  <= r_cnt + CW'(1);
              r_en   <= 1'b1;
              r_addr <= AW'(w_rd_idx) << ADDR_SHIFT;
            end
          end
        end
        S_LTAIL: begin
          r_cnt <= '0;
          r_tmo <= '0;
        end
        S_RUN: begin
          if (!abort && !ntt_done) begin
            if (w_tmo_hit) r_err <= 1'b1;
            else           r_tmo <= r_tmo + TW'(1);
          end
        end
        default: ;
      endcase
      if (w_wr_issue) begin
        r_en   <= 1'b1;
        r_we   <= 1'b1;
        r_din  <= st_data;
        r_addr <= AW'(w_wr_idx) << ADDR_SHIFT;
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign err       = r_err;
  assign BRAM_clk  = clk;
  assign BRAM_en   = r_en;
  assign BRAM_we   = r_we;
  assign BRAM_addr = r_addr;
  assign BRAM_din  = r_din;
  assign ld_valid  = r_ld_valid;
  assign ld_idx    = r_ld_idx;
  assign ld_data   = BRAM_dout;
  assign st_idx    = r_cnt[LW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_ntt_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_seq_ctrl
// Brief    : Directed self-checking bench for ntt_seq_ctrl with a BRAM model
//            and a simple NTT core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_seq_ctrl;

  localparam int N   = 64;
  localparam int DW  = 64;
  localparam int AW  = 13;
  localparam int AS  = 2;
  localparam int TMO = 16;
  localparam int WW  = AW - AS;
  localparam int LW  = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] src_base = '0;
  logic [WW-1:0] dst_base = '0;
  logic          busy, done_o, err, BRAM_clk, BRAM_en, BRAM_we;
  logic [AW-1:0] BRAM_addr;
  logic [DW-1:0] BRAM_din;
  logic [DW-1:0] BRAM_dout = '0;
  logic          ntt_rst, ntt_done, ld_valid;
  logic [LW-1:0] ld_idx, st_idx;
  logic [DW-1:0] ld_data, st_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run_cnt = 0;
  logic done_en = 1'b1;
  logic force_done = 1'b0;

  ntt_seq_ctrl #(.N(N), .DW(DW), .AW(AW), .ADDR_SHIFT(AS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base),
    .busy(busy), .done_o(done_o), .err(err),
    .BRAM_clk(BRAM_clk), .BRAM_en(BRAM_en), .BRAM_we(BRAM_we),
    .BRAM_addr(BRAM_addr), .BRAM_din(BRAM_din), .BRAM_dout(BRAM_dout),
    .ntt_rst(ntt_rst), .ntt_done(ntt_done),
    .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data),
    .st_idx(st_idx), .st_data(st_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_st(input int i);
    return 64'hA500_0000 + 64'(i) * 7;
  endfunction

  // BRAM model: one-cycle read latency
  logic [DW-1:0] mem [0:(1<<WW)-1];
  always @(posedge clk) begin
    if (BRAM_en) begin
      if (BRAM_we) mem[BRAM_addr[AW-1:AS]] <= BRAM_din;
      else         BRAM_dout <= mem[BRAM_addr[AW-1:AS]];
    end
  end

  // NTT core model: done in the 10th cycle after reset release
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    run_cnt <= ntt_rst ? 0 : run_cnt + 1;
  end
  assign ntt_done = force_done | (done_en & ~ntt_rst & (run_cnt == 9));
  assign st_data  = exp_st(int'(st_idx));

  // Event logs
  int            q_rd_cyc[$], q_rd_addr[$], q_wr_cyc[$], q_wr_addr[$];
  logic [DW-1:0] q_wr_data[$];
  int            q_ld_idx[$];
  logic [DW-1:0] q_ld_data[$];
  int            q_ld_cyc[$], q_done_cyc[$];
  logic          q_done_err[$], q_done_busy[$];
  int            n_busy = 0, n_nrst0 = 0, first_nrst0 = -1;

  always @(negedge clk) begin
    if (BRAM_en && !BRAM_we) begin q_rd_cyc.push_back(cyc); q_rd_addr.push_back(int'(BRAM_addr)); end
    if (BRAM_en && BRAM_we) begin
      q_wr_cyc.push_back(cyc); q_wr_addr.push_back(int'(BRAM_addr)); q_wr_data.push_back(BRAM_din);
    end
    if (ld_valid) begin q_ld_idx.push_back(int'(ld_idx)); q_ld_data.push_back(ld_data); q_ld_cyc.push_back(cyc); end
    if (done_o) begin q_done_cyc.push_back(cyc); q_done_err.push_back(err); q_done_busy.push_back(busy); end
    if (busy) n_busy++;
    if (!ntt_rst) begin if (first_nrst0 < 0) first_nrst0 = cyc; n_nrst0++; end
  end

  task automatic clear_logs();
    q_rd_cyc.delete(); q_rd_addr.delete(); q_wr_cyc.delete(); q_wr_addr.delete(); q_wr_data.delete();
    q_ld_idx.delete(); q_ld_data.delete(); q_ld_cyc.delete();
    q_done_cyc.delete(); q_done_err.delete(); q_done_busy.delete();
    n_busy = 0; n_nrst0 = 0; first_nrst0 = -1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int s, input int d, output int t);
    src_base = WW'(s); dst_base = WW'(d); start = 1'b1; t = cyc;
    tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      tick();
      if (q_done_cyc.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    checks++;
    if ({busy, done_o, err, BRAM_en, BRAM_we, ld_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=000000", {busy, done_o, err, BRAM_en, BRAM_we, ld_valid});
    end
    checks++;
    if (BRAM_addr !== '0 || BRAM_din !== '0 || ld_idx !== '0 || st_idx !== '0) begin
      errors++; $display("FAIL reset_buses addr=%0d din=%0h ld_idx=%0d st_idx=%0d want all 0", BRAM_addr, BRAM_din, ld_idx, st_idx);
    end
    checks++;
    if (ntt_rst !== 1'b1) begin errors++; $display("FAIL reset_ntt_rst got=%b want=1", ntt_rst); end
  endtask

  task automatic test_nominal();
    int t; bit ok; int bad;
    for (int i = 0; i < N; i++) mem[i] = 64'(i + 1);
    clear_logs();
    do_start(0, 64, t);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy_t1 got=%b want=1", busy); end
    wait_done(1, ok);
    repeat (5) tick();
    checks++;
    if (!ok) begin errors++; $display("FAIL nom_timeout got=no_done want=done"); end
    checks++;
    if (q_ld_idx.size() != N || q_rd_addr.size() != N || q_wr_addr.size() != N) begin
      errors++; $display("FAIL nom_counts ld=%0d rd=%0d wr=%0d want=%0d each", q_ld_idx.size(), q_rd_addr.size(), q_wr_addr.size(), N);
    end else begin
      bad = 0;
      for (int i = 0; i < N; i++) begin
        if (q_ld_idx[i] != i || q_ld_data[i] !== 64'(i + 1) || q_rd_addr[i] != 4 * i) bad++;
        if (q_wr_addr[i] != 256 + 4 * i || q_wr_data[i] !== exp_st(i)) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL nom_data_addr got=%0d bad entries want=0", bad); end
      checks++;
      if (q_rd_cyc[0] != t + 1 || q_ld_cyc[0] != t + 2 || q_ld_cyc[N-1] != t + N + 1) begin
        errors++; $display("FAIL nom_load_timing rd0=%0d ld0=%0d ldN=%0d want=%0d %0d %0d",
                           q_rd_cyc[0] - t, q_ld_cyc[0] - t, q_ld_cyc[N-1] - t, 1, 2, N + 1);
      end
      checks++;
      if (q_wr_cyc[0] != t + N + 12 || q_wr_cyc[N-1] != t + 2 * N + 11) begin
        errors++; $display("FAIL nom_write_timing first=%0d last=%0d want=%0d %0d", q_wr_cyc[0] - t, q_wr_cyc[N-1] - t, N + 12, 2 * N + 11);
      end
    end
    checks++;
    if (q_done_cyc.size() != 1 || q_done_cyc[0] != t + 2 * N + 12 || q_done_busy[0] !== 1'b0 || q_done_err[0] !== 1'b0) begin
      errors++; $display("FAIL nom_done n=%0d at=%0d want n=1 at=%0d busy=0 err=0", q_done_cyc.size(),
                         (q_done_cyc.size() > 0) ? q_done_cyc[0] - t : -1, 2 * N + 12);
    end
    checks++;
    if (n_busy != 2 * N + 11 || first_nrst0 != t + N + 2 || n_nrst0 != N + 10) begin
      errors++; $display("FAIL nom_busy_nttrst busy=%0d nrst0_at=%0d nrst0_len=%0d want=%0d %0d %0d",
                         n_busy, first_nrst0 - t, n_nrst0, 2 * N + 11, N + 2, N + 10);
    end
  endtask

  task automatic test_wrap();
    int t; bit ok; int bad;
    mem[2045] = 64'h111; mem[2046] = 64'h222; mem[2047] = 64'h333;
    clear_logs();
    do_start(2045, 300, t);
    wait_done(1, ok);
    repeat (3) tick();
    checks++;
    if (!ok || q_rd_addr.size() != N || q_ld_data.size() != N) begin
      errors++; $display("FAIL wrap_run ok=%0d rd=%0d ld=%0d want 1 %0d %0d", ok, q_rd_addr.size(), q_ld_data.size(), N, N);
    end else begin
      checks++;
      if (q_rd_addr[0] != 8180 || q_rd_addr[1] != 8184 || q_rd_addr[2] != 8188 || q_rd_addr[3] != 0 || q_rd_addr[4] != 4) begin
        errors++; $display("FAIL wrap_addr got=%0d,%0d,%0d,%0d,%0d want=8180,8184,8188,0,4",
                           q_rd_addr[0], q_rd_addr[1], q_rd_addr[2], q_rd_addr[3], q_rd_addr[4]);
      end
      bad = 0;
      for (int i = 3; i < N; i++) if (q_rd_addr[i] != 4 * (i - 3)) bad++;
      checks++;
      if (bad != 0 || q_ld_data[0] !== 64'h111 || q_ld_data[2] !== 64'h333 || q_ld_data[3] !== 64'h1) begin
        errors++; $display("FAIL wrap_data bad=%0d d0=%0h d2=%0h d3=%0h want 0 111 333 1", bad, q_ld_data[0], q_ld_data[2], q_ld_data[3]);
      end
    end
  endtask

  task automatic test_timeout();
    int t; bit ok;
    done_en = 1'b0;
    clear_logs();
    do_start(0, 500, t);
    wait_done(1, ok);
    repeat (10) tick();
    checks++;
    if (!ok || q_done_cyc.size() != 1 || q_done_cyc[0] != t + N + 18 || q_done_err[0] !== 1'b1 || q_done_busy[0] !== 1'b0) begin
      errors++; $display("FAIL tmo_done n=%0d at=%0d want n=1 at=%0d err=1 busy=0", q_done_cyc.size(),
                         (q_done_cyc.size() > 0) ? q_done_cyc[0] - t : -1, N + 18);
    end
    checks++;
    if (q_wr_cyc.size() != 0) begin errors++; $display("FAIL tmo_writes got=%0d want=0", q_wr_cyc.size()); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky got=%b want=1", err); end
    done_en = 1'b1;
    clear_logs();
    do_start(0, 500, t);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear got=%b want=0", err); end
    wait_done(1, ok);
    repeat (3) tick();
    checks++;
    if (!ok || q_done_err[0] !== 1'b0 || q_wr_cyc.size() != N) begin
      errors++; $display("FAIL tmo_rerun ok=%0d wr=%0d want ok=1 wr=%0d err=0", ok, q_wr_cyc.size(), N);
    end
  endtask

  task automatic test_abort();
    int t;
    clear_logs();
    do_start(0, 64, t);
    while (cyc < t + 31) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || ntt_rst !== 1'b1 || BRAM_en !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL abort_load busy=%b ntt_rst=%b en=%b done=%b want 0 1 0 0", busy, ntt_rst, BRAM_en, done_o);
    end
    repeat (100) tick();
    checks++;
    if (q_done_cyc.size() != 0 || q_rd_cyc.size() != 31 || err !== 1'b0) begin
      errors++; $display("FAIL abort_load_after done=%0d reads=%0d err=%b want 0 31 0", q_done_cyc.size(), q_rd_cyc.size(), err);
    end
    clear_logs();
    do_start(0, 64, t);
    while (cyc < t + N + 16) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || ntt_rst !== 1'b1 || BRAM_en !== 1'b0 || BRAM_we !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL abort_store busy=%b ntt_rst=%b en=%b we=%b done=%b want 0 1 0 0 0",
                         busy, ntt_rst, BRAM_en, BRAM_we, done_o);
    end
    repeat (100) tick();
    checks++;
    if (q_done_cyc.size() != 0 || q_wr_cyc.size() != 5) begin
      errors++; $display("FAIL abort_store_after done=%0d writes=%0d want 0 5", q_done_cyc.size(), q_wr_cyc.size());
    end else begin
      checks++;
      if (q_wr_data[4] !== exp_st(4) || q_wr_addr[4] != 256 + 16) begin
        errors++; $display("FAIL abort_store_data d4=%0h a4=%0d want %0h %0d", q_wr_data[4], q_wr_addr[4], exp_st(4), 272);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t; int n;
    clear_logs();
    src_base = '0; dst_base = WW'(64);
    start = 1'b1; t = cyc; n = 0;
    for (int k = 0; k < 700; k++) begin
      tick();
      if (done_o) n++;
      if (n == 2) break;
    end
    start = 1'b0;
    checks++;
    if (n != 2) begin errors++; $display("FAIL b2b_timeout got=%0d dones want=2", n); end
    repeat (100) tick();
    checks++;
    if (q_done_cyc.size() != 2 || n_busy != 2 * (2 * N + 11) || q_rd_cyc.size() != 2 * N) begin
      errors++; $display("FAIL b2b_counts done=%0d busy=%0d reads=%0d want 2 %0d %0d",
                         q_done_cyc.size(), n_busy, q_rd_cyc.size(), 2 * (2 * N + 11), 2 * N);
    end else begin
      checks++;
      if (q_done_cyc[0] != t + 2 * N + 12 || q_rd_cyc[N] != t + 2 * N + 14 || q_done_cyc[1] != t + 4 * N + 25) begin
        errors++; $display("FAIL b2b_timing done0=%0d rd2=%0d done1=%0d want %0d %0d %0d",
                           q_done_cyc[0] - t, q_rd_cyc[N] - t, q_done_cyc[1] - t, 2 * N + 12, 2 * N + 14, 4 * N + 25);
      end
    end
  endtask

  task automatic test_rst_in_run();
    int t;
    clear_logs();
    do_start(0, 64, t);
    while (cyc < t + N + 5) tick();
    rst = 1'b1; force_done = 1'b1; abort = 1'b1; tick();
    rst = 1'b0; force_done = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, done_o, err, BRAM_en, BRAM_we, ld_valid, ntt_rst} !== 7'b0000001 ||
        BRAM_addr !== '0 || BRAM_din !== '0 || ld_idx !== '0 || st_idx !== '0) begin
      errors++; $display("FAIL rst_run flags=%b addr=%0d din=%0h ld_idx=%0d st_idx=%0d want 0000001 0 0 0 0",
                         {busy, done_o, err, BRAM_en, BRAM_we, ld_valid, ntt_rst}, BRAM_addr, BRAM_din, ld_idx, st_idx);
    end
    repeat (50) tick();
    checks++;
    if (q_wr_cyc.size() != 0 || q_done_cyc.size() != 0) begin
      errors++; $display("FAIL rst_run_after writes=%0d done=%0d want 0 0", q_wr_cyc.size(), q_done_cyc.size());
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << WW); i++) mem[i] = '0;
    test_reset();
    test_nominal();
    test_wrap();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_rst_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
